// File: rtl/power_pkg.sv
// power_pkg: shared types and constants for the power_n scheduler
package power_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam int OPW  = 3;
   localparam int RESW = 8;

   // bit {base, exponent} is set when base**exponent > 255
   localparam logic [63:0] OVF_LUT = 64'hF8F0_F0F0_C000_0000;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin winner search starting at an internally held pointer
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic                    advance,
   output logic [NREQ-1:0]         win_oh,
   output logic [$clog2(NREQ)-1:0] win_idx
);

   localparam int IW = $clog2(NREQ);

   logic [IW-1:0] rr_ptr;

   // scan from the highest offset down so the lowest offset from rr_ptr wins
   always_comb begin
      int j;
      j = 0;
      win_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(rr_ptr) + k;
         j = (j >= NREQ) ? j - NREQ : j;
         win_idx = req[j] ? IW'(j) : win_idx;
      end
      win_oh = |req ? NREQ'(1) << win_idx : '0;
   end

   // pointer moves just past the accepted winner
   always_ff @(posedge clk) begin
      if (reset)
         rr_ptr <= '0;
      else if (advance)
         rr_ptr <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
   end

endmodule

// File: rtl/power_n_sched.sv
// power_n_sched: round-robin sharing of one power_n unit; define POWER_SCHED_OVF_EN to build the overflow flag
module power_n_sched
   import power_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int PN_LATENCY = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [3*NREQ-1:0]       base_in,
   input  logic [3*NREQ-1:0]       exp_in,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   output logic                    rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [RESW-1:0]         rsp_data,
   output logic                    rsp_ovf,
   output logic                    pn_start,
   output logic [OPW-1:0]          pn_base,
   output logic [OPW-1:0]          pn_exponent,
   input  logic [RESW-1:0]         pn_out
);

   localparam int IW = $clog2(NREQ);

   state_t          state, nxt;
   logic [3:0]      cnt;
   logic [IW-1:0]   id, win_idx;
   logic [NREQ-1:0] id_oh, win_oh;
   logic            accept, capture;

   assign accept  = (state == IDLE) && |req;
   assign capture = (state == WAIT) && (cnt == '0);
   assign rsp_id  = id;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .advance (accept),
      .win_oh  (win_oh),
      .win_idx (win_idx)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= nxt;
   end

   // next state and state-decoded strobes
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = accept ? ISSUE : IDLE;
         ISSUE:   nxt = WAIT;
         WAIT:    nxt = capture ? DONE : WAIT;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      busy      = state != IDLE;
      pn_start  = state == ISSUE;
      gnt       = pn_start ? id_oh : '0;
      rsp_valid = state == DONE;
   end

   // latch the winner on accept, run the latency counter, capture the result
   always_ff @(posedge clk) begin
      if (reset) begin
         id          <= '0;
         id_oh       <= '0;
         pn_base     <= '0;
         pn_exponent <= '0;
         cnt         <= '0;
         rsp_data    <= '0;
      end else begin
         if (accept) begin
            id          <= win_idx;
            id_oh       <= win_oh;
            pn_base     <= base_in[3*win_idx +: 3];
            pn_exponent <= exp_in[3*win_idx +: 3];
         end
         if (state == ISSUE)
            cnt <= 4'(PN_LATENCY - 1);
         else if (state == WAIT && cnt != '0)
            cnt <= cnt - 1'b1;
         if (capture)
            rsp_data <= pn_out;
      end
   end

`ifdef POWER_SCHED_OVF_EN
   // overflow flag looked up from the held operands, registered with rsp_data
   always_ff @(posedge clk) begin
      if (reset)
         rsp_ovf <= 1'b0;
      else if (capture)
         rsp_ovf <= OVF_LUT[{pn_base, pn_exponent}];
   end
`else
   assign rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_power_n_sched.sv
// tb_power_n_sched: randomized scoreboard bench with a behavioural power_n model and arbitration model
module tb_power_n_sched;

   localparam int NREQ = 4;
   localparam int L    = 8;
   localparam int IW   = $clog2(NREQ);

   typedef struct {
      int id;
      int data;
      int ovf;
      int cyc;
   } rsp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NREQ-1:0]   req, gnt;
   logic [3*NREQ-1:0] base_in, exp_in;
   logic              busy, rsp_valid, rsp_ovf, pn_start;
   logic [IW-1:0]     rsp_id;
   logic [7:0]        rsp_data;
   logic [7:0]        pn_out = '0;
   logic [2:0]        pn_base, pn_exponent;

   logic [NREQ-1:0]   pend = '0;
   logic [NREQ-1:0]   hold = '0;
   logic [2:0]        b [NREQ];
   logic [2:0]        e [NREQ];

   rsp_t q[$];
   int   gnt_log[$];
   int   vectors = 0, miscompares = 0;
   int   cyc = 0, mptr = 0, last_gnt = -1, rsp_count = 0;
   int   s_cyc = -100, s_val = 0;
   bit   b2b = 1'b0, got_gnt = 1'b0;

   power_n_sched #(.NREQ(NREQ), .PN_LATENCY(L)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .base_in     (base_in),
      .exp_in      (exp_in),
      .gnt         (gnt),
      .busy        (busy),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .rsp_ovf     (rsp_ovf),
      .pn_start    (pn_start),
      .pn_base     (pn_base),
      .pn_exponent (pn_exponent),
      .pn_out      (pn_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign req = pend;
   always_comb begin
      base_in = '0;
      exp_in  = '0;
      for (int i = 0; i < NREQ; i++) begin
         base_in[3*i +: 3] = b[i];
         exp_in[3*i +: 3]  = e[i];
      end
   end

   function automatic int pw(int bb, int ee);
      int p = 1;
      for (int k = 0; k < ee; k++) p = p * bb;
      return p;
   endfunction

   // power_n model: result valid only in the cycle PN_LATENCY after start, noise otherwise
   always @(negedge clk) begin
      if (pn_start === 1'b1) begin
         s_cyc = cyc;
         s_val = pw(int'(pn_base), int'(pn_exponent));
      end
      pn_out = (cyc == s_cyc + L) ? 8'(s_val) : 8'($urandom);
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int pick();
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = (mptr + k) % NREQ;
         if (pend[j]) return j;
      end
      return -1;
   endfunction

   task automatic handle_gnt();
      int   w, p;
      rsp_t r;
      got_gnt = 1'b1;
      w = pick();
      if (w < 0) begin
         chk("gnt_spurious", 32'(gnt), 0);
         return;
      end
      chk("gnt_onehot", 32'(gnt), 32'(1) << w);
      chk("gnt_pn_start", 32'(pn_start), 1);
      chk("gnt_busy", 32'(busy), 1);
      chk("gnt_pn_base", 32'(pn_base), 32'(b[w]));
      chk("gnt_pn_exponent", 32'(pn_exponent), 32'(e[w]));
      if (b2b && last_gnt >= 0) chk("gnt_gap", cyc - last_gnt, L + 3);
      last_gnt = cyc;
      gnt_log.push_back(w);
      mptr = (w + 1) % NREQ;
      p = pw(int'(b[w]), int'(e[w]));
      r.id   = w;
      r.data = p % 256;
`ifdef POWER_SCHED_OVF_EN
      r.ovf  = (p > 255) ? 1 : 0;
`else
      r.ovf  = 0;
`endif
      r.cyc  = cyc;
      q.push_back(r);
      if (hold[w]) hold[w] = 1'b0;
      else pend[w] = 1'b0;
   endtask

   // response monitor: every rsp_valid must match the oldest expected job
   always @(negedge clk) begin
      if (!reset && rsp_valid === 1'b1) begin
         rsp_count++;
         if (q.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 0);
         end else begin
            rsp_t x;
            x = q.pop_front();
            chk("rsp_id", 32'(rsp_id), x.id);
            chk("rsp_data", 32'(rsp_data), x.data);
            chk("rsp_ovf", 32'(rsp_ovf), x.ovf);
            chk("rsp_latency", cyc - x.cyc, L + 1);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      if (!reset && gnt !== '0) handle_gnt();
   endtask

   task automatic check_zero();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_rsp_ovf", 32'(rsp_ovf), 0);
      chk("rst_pn_start", 32'(pn_start), 0);
      chk("rst_pn_base", 32'(pn_base), 0);
      chk("rst_pn_exponent", 32'(pn_exponent), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      check_zero();
      @(negedge clk);
      reset = 1'b0;
      pend = '0;
      hold = '0;
      mptr = 0;
      last_gnt = -1;
      q.delete();
      gnt_log.delete();
   endtask

   task automatic drain();
      int n = 0;
      while ((pend != '0 || busy || q.size() != 0) && n < 2000) begin
         step();
         n++;
      end
      chk("drain_timeout", 32'(n < 2000), 1);
   endtask

   initial begin
      int n, n1;
      for (int i = 0; i < NREQ; i++) begin
         b[i] = '0;
         e[i] = '0;
      end
      do_reset();

      // single request from idle: grant in the very next cycle
      b[0] = 3'd4; e[0] = 3'd2; pend[0] = 1'b1;
      got_gnt = 1'b0;
      step();
      chk("single_gnt_latency", 32'(got_gnt), 1);
      drain();

      // all four at once from pointer 0
      do_reset();
      b[0] = 3'd3; e[0] = 3'd5;
      b[1] = 3'd6; e[1] = 3'd3;
      b[2] = 3'd5; e[2] = 3'd2;
      b[3] = 3'd4; e[3] = 3'd2;
      pend = '1;
      b2b = 1'b1;
      drain();
      b2b = 1'b0;
      chk("all4_count", gnt_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("all4_order", gnt_log[i], i);

      // fairness: after granting 2, requester 3 beats requester 0
      do_reset();
      b[2] = 3'd2; e[2] = 3'd1; pend[2] = 1'b1;
      drain();
      b[0] = 3'd1; e[0] = 3'd7; b[3] = 3'd0; e[3] = 3'd0;
      pend[0] = 1'b1; pend[3] = 1'b1;
      drain();
      chk("rr_second", gnt_log[1], 3);
      chk("rr_third", gnt_log[2], 0);

      // overflowing result
      b[3] = 3'd7; e[3] = 3'd3; pend[3] = 1'b1;
      drain();

      // reset during WAIT drops the job and restarts arbitration at 0
      b[1] = 3'd3; e[1] = 3'd3; pend[1] = 1'b1;
      got_gnt = 1'b0;
      n = 0;
      while (!got_gnt && n < 50) begin
         step();
         n++;
      end
      chk("rst_job_granted", 32'(got_gnt), 1);
      repeat (3) step();
      do_reset();
      repeat (L + 6) step();
      b[0] = 3'd2; e[0] = 3'd3; b[2] = 3'd6; e[2] = 3'd2;
      pend[0] = 1'b1; pend[2] = 1'b1;
      drain();
      chk("rst_restart_first", gnt_log[0], 0);

      // requester holding req past DONE is granted again
      n1 = rsp_count;
      b[1] = 3'd5; e[1] = 3'd3; pend[1] = 1'b1; hold[1] = 1'b1;
      drain();
      chk("hold_regrant", rsp_count - n1, 2);

      // random traffic
      repeat (60) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               b[i] = 3'($urandom_range(0, 7));
               e[i] = 3'($urandom_range(0, 7));
               hold[i] = ($urandom_range(0, 7) == 0);
               pend[i] = 1'b1;
            end
         end
         repeat ($urandom_range(0, 14)) step();
      end
      drain();
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
